atax_param_core: RTL and testbench

ATAX_PARAM_CORE -- requirements
Module: atax_param_core

---
 rtl/atax_pkg.sv | 19 +
 rtl/atax_param_core_mac.sv | 11 +
 rtl/atax_param_core.sv | 121 ++++++++++++
 tb/tb_atax_param_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/atax_pkg.sv
// atax_pkg: shared FSM state type and width helpers for the ATAX core
package atax_pkg;
  typedef enum logic [2:0] {IDLE, CLR, P1, P2, WR, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int a_aw(input int r, input int c);
    return clog2(r * c);
  endfunction
  function automatic int x_aw(input int c);
    return clog2(c);
  endfunction
  function automatic int y_aw(input int r, input int c);
    return clog2(r > c ? r : c);
  endfunction
endpackage

// File: rtl/atax_param_core_mac.sv
// atax_mac: wrapping signed multiply-add, y = a*b + c modulo 2^DATA_W
module atax_mac #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  output logic signed [DATA_W-1:0] y
);
  assign y = a * b + c;
endmodule

// File: rtl/atax_param_core.sv
// atax_param_core: y = A^T(A x) (mode 0) or y = A x (mode 1) over external 1-cycle-latency memories
module atax_param_core
  import atax_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  localparam int A_AW = a_aw(N_ROWS, N_COLS),
  localparam int X_AW = x_aw(N_COLS),
  localparam int Y_AW = y_aw(N_ROWS, N_COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  output logic                     finish,
  output logic [A_AW-1:0]          main_A_address_a,
  output logic                     main_A_enable_a,
  input  logic signed [DATA_W-1:0] main_A_out_a,
  output logic [X_AW-1:0]          main_x_address_a,
  output logic                     main_x_enable_a,
  input  logic signed [DATA_W-1:0] main_x_out_a,
  output logic [Y_AW-1:0]          main_y_address_a,
  output logic                     main_y_enable_a,
  output logic                     main_y_write_enable_a,
  output logic signed [DATA_W-1:0] main_y_in_a
);
  localparam logic [15:0] LC = 16'(N_COLS);
  localparam logic [15:0] LR = 16'(N_ROWS);
  state_t state;
  logic md, rd, wr_row;
  logic [15:0] cnt, row;
  logic [A_AW-1:0] base;
  logic [X_AW-1:0] jm;
  logic signed [DATA_W-1:0] tmp, mb, mc, mr;
  logic signed [DATA_W-1:0] acc [N_COLS];
  // one MAC: P1 folds A*x into tmp, P2 folds A*tmp into acc[j-1]
  assign jm = X_AW'(cnt - 16'd1);
  assign mb = state == P2 ? tmp : main_x_out_a;
  assign mc = state == P2 ? acc[jm] : tmp;
  atax_mac #(.DATA_W(DATA_W)) u_mac (
    .a(main_A_out_a),
    .b(mb),
    .c(mc),
    .y(mr)
  );
  assign rd = cnt < LC;
  assign wr_row = state == P1 && md && cnt == LC + 16'd1;
  assign main_A_enable_a = (state == P1 || state == P2) && rd;
  assign main_A_address_a = base + A_AW'(cnt);
  assign main_x_enable_a = state == P1 && rd;
  assign main_x_address_a = X_AW'(cnt);
  assign main_y_enable_a = wr_row || state == WR;
  assign main_y_write_enable_a = main_y_enable_a;
  assign main_y_address_a = state == WR ? Y_AW'(cnt) : Y_AW'(row);
  assign main_y_in_a = state == WR ? acc[X_AW'(cnt)] : tmp;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      md <= 1'b0;
      cnt <= '0;
      row <= '0;
      base <= '0;
      tmp <= '0;
      finish <= 1'b0;
      for (int k = 0; k < N_COLS; k++) acc[k] <= '0;
    end else begin
      finish <= state == DONE;
      case (state)
        IDLE: if (start) begin
          md <= mode;
          state <= CLR;
        end
        CLR: begin
          for (int k = 0; k < N_COLS; k++) acc[k] <= '0;
          tmp <= '0;
          row <= '0;
          base <= '0;
          cnt <= '0;
          state <= P1;
        end
        P1: begin
          if (cnt >= 16'd1 && cnt <= LC) tmp <= mr;
          if (cnt == LC + 16'd1) begin
            cnt <= '0;
            if (md) begin
              tmp <= '0;
              row <= row + 16'd1;
              base <= base + A_AW'(N_COLS);
              state <= row == LR - 16'd1 ? DONE : P1;
            end else begin
              state <= P2;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        P2: begin
          if (cnt >= 16'd1) acc[jm] <= mr;
          if (cnt == LC) begin
            cnt <= '0;
            tmp <= '0;
            row <= row + 16'd1;
            base <= base + A_AW'(N_COLS);
            state <= row == LR - 16'd1 ? WR : P1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR: if (cnt == LC - 16'd1) begin
          cnt <= '0;
          state <= DONE;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_atax_param_core.sv
// tb_atax_param_core: directed vector checks of atax_param_core in three configurations
module tb_atax_param_core;
  logic clk = 0, rst;
  logic [2:0] st, md, fin;
  always #5 clk = ~clk;

  logic [3:0] aa0; logic [1:0] xa0, ya0; logic ae0, xe0, ye0, ywe0;
  logic signed [31:0] ao0, xo0, yd0;
  logic [0:0] aa1, xa1, ya1; logic ae1, xe1, ye1, ywe1;
  logic signed [7:0] ao1, xo1, yd1;
  logic [2:0] aa2; logic [0:0] xa2; logic [1:0] ya2; logic ae2, xe2, ye2, ywe2;
  logic signed [31:0] ao2, xo2, yd2;

  logic signed [31:0] a0 [16], x0 [4], a2 [6], x2 [2];
  logic signed [7:0] a1, x1;

  atax_param_core #(.DATA_W(32), .N_ROWS(4), .N_COLS(4)) u0 (
    .clk(clk), .reset(rst), .start(st[0]), .mode(md[0]), .finish(fin[0]),
    .main_A_address_a(aa0), .main_A_enable_a(ae0), .main_A_out_a(ao0),
    .main_x_address_a(xa0), .main_x_enable_a(xe0), .main_x_out_a(xo0),
    .main_y_address_a(ya0), .main_y_enable_a(ye0), .main_y_write_enable_a(ywe0), .main_y_in_a(yd0));
  atax_param_core #(.DATA_W(8), .N_ROWS(1), .N_COLS(1)) u1 (
    .clk(clk), .reset(rst), .start(st[1]), .mode(md[1]), .finish(fin[1]),
    .main_A_address_a(aa1), .main_A_enable_a(ae1), .main_A_out_a(ao1),
    .main_x_address_a(xa1), .main_x_enable_a(xe1), .main_x_out_a(xo1),
    .main_y_address_a(ya1), .main_y_enable_a(ye1), .main_y_write_enable_a(ywe1), .main_y_in_a(yd1));
  atax_param_core #(.DATA_W(32), .N_ROWS(3), .N_COLS(2)) u2 (
    .clk(clk), .reset(rst), .start(st[2]), .mode(md[2]), .finish(fin[2]),
    .main_A_address_a(aa2), .main_A_enable_a(ae2), .main_A_out_a(ao2),
    .main_x_address_a(xa2), .main_x_enable_a(xe2), .main_x_out_a(xo2),
    .main_y_address_a(ya2), .main_y_enable_a(ye2), .main_y_write_enable_a(ywe2), .main_y_in_a(yd2));

  always @(posedge clk) begin
    if (ae0) ao0 <= a0[aa0];
    if (xe0) xo0 <= x0[xa0];
    if (ae1) ao1 <= a1;
    if (xe1) xo1 <= x1;
    if (ae2) ao2 <= a2[aa2];
    if (xe2) xo2 <= x2[xa2];
  end

  int wcnt [3], fcnt [3], wa [3][8];
  logic signed [31:0] wd [3][8];
  always @(negedge clk) begin
    if (ye0 && ywe0) begin
      if (wcnt[0] < 8) begin wa[0][wcnt[0]] = int'(ya0); wd[0][wcnt[0]] = yd0; end
      wcnt[0]++;
    end
    if (ye1 && ywe1) begin
      if (wcnt[1] < 8) begin wa[1][wcnt[1]] = int'(ya1); wd[1][wcnt[1]] = yd1; end
      wcnt[1]++;
    end
    if (ye2 && ywe2) begin
      if (wcnt[2] < 8) begin wa[2][wcnt[2]] = int'(ya2); wd[2][wcnt[2]] = yd2; end
      wcnt[2]++;
    end
    for (int i = 0; i < 3; i++) if (fin[i]) fcnt[i]++;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int d, input logic m, input int lat, input int nw, input logic [3:0][31:0] ey);
    int got;
    logic signed [31:0] ev;
    wcnt[d] = 0;
    fcnt[d] = 0;
    md[d] = m;
    st[d] = 1;
    @(posedge clk); #1;
    st[d] = 0;
    got = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (fin[d]) begin got = c; break; end
    end
    chk($sformatf("dut%0d_latency", d), got, lat);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("dut%0d_write_count", d), wcnt[d], nw);
    chk($sformatf("dut%0d_finish_pulses", d), fcnt[d], 1);
    for (int k = 0; k < nw && k < 8; k++) begin
      ev = ey[k];
      chk($sformatf("dut%0d_y%0d_addr", d, k), wa[d][k], k);
      chk($sformatf("dut%0d_y%0d_data", d, k), wd[d][k], ev);
    end
  endtask

  typedef struct packed {
    logic m;
    logic [15:0][31:0] a;
    logic [3:0][31:0] x;
    logic [3:0][31:0] y;
    logic [7:0] lat;
  } vec_t;
  vec_t tv [8];

  task automatic load0(input vec_t v);
    for (int k = 0; k < 16; k++) a0[k] = v.a[k];
    for (int k = 0; k < 4; k++) x0[k] = v.x[k];
  endtask

  initial begin
    logic [3:0][31:0] e;
    int sec;
    for (int v = 0; v < 8; v++) tv[v] = '0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      tv[0].a[i*4+j] = i + j;
      tv[2].a[i*4+j] = (i == j) ? 1 : 0;
      tv[4].a[i*4+j] = 1;
    end
    for (int j = 0; j < 4; j++) begin
      tv[0].x[j] = j + 1;
      tv[4].x[j] = j + 1;
      tv[0].y[j] = 260 + 140 * j;
      tv[4].y[j] = 40;
    end
    tv[0].lat = 50;
    tv[2].x = {32'sd2, 32'sd7, -32'sd3, 32'sd5};
    tv[2].y = tv[2].x;
    tv[2].lat = 50;
    tv[4].lat = 50;
    tv[6].a[0] = 65536;
    tv[6].x[0] = 65537;
    tv[6].y[0] = 0;
    tv[6].lat = 50;
    tv[1] = tv[0]; tv[1].m = 1; tv[1].lat = 26;
    for (int j = 0; j < 4; j++) tv[1].y[j] = 20 + 10 * j;
    tv[3] = tv[2]; tv[3].m = 1; tv[3].lat = 26;
    tv[5] = tv[4]; tv[5].m = 1; tv[5].lat = 26;
    for (int j = 0; j < 4; j++) tv[5].y[j] = 10;
    tv[7] = tv[6]; tv[7].m = 1; tv[7].lat = 26; tv[7].y[0] = 65536;

    rst = 1; st = '0; md = '0;
    for (int i = 0; i < 3; i++) begin wcnt[i] = 0; fcnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_finish", fin, 0);
    chk("reset_a_en", {ae0, ae1, ae2}, 0);
    chk("reset_y_en", {ye0, ye1, ye2}, 0);

    for (int v = 0; v < 8; v++) begin
      load0(tv[v]);
      run(0, tv[v].m, int'(tv[v].lat), 4, tv[v].y);
    end

    load0(tv[0]);
    wcnt[0] = 0; fcnt[0] = 0; md[0] = 0; st[0] = 1;
    @(posedge clk); #1;
    st[0] = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_a_en", ae0, 0);
    chk("abort_x_en", xe0, 0);
    chk("abort_y_en", ye0, 0);
    chk("abort_finish", fin[0], 0);
    repeat (60) @(posedge clk);
    #1;
    chk("abort_writes", wcnt[0], 0);
    chk("abort_finishes", fcnt[0], 0);
    run(0, 0, 50, 4, tv[0].y);

    wcnt[0] = 0; fcnt[0] = 0; md[0] = 0; st[0] = 1;
    @(posedge clk); #1;
    sec = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c > 50 && ae0 && sec < 0) sec = c;
    end
    st[0] = 0;
    chk("held_finishes", fcnt[0], 1);
    chk("held_rerun_cycle", sec, 52);
    chk("held_writes", wcnt[0], 4);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;

    a1 = 100; x1 = 3;
    e = '0; e[0] = 44;
    run(1, 1, 5, 1, e);
    e[0] = 48;
    run(1, 0, 8, 1, e);

    a2[0] = 1; a2[1] = 2; a2[2] = 3; a2[3] = 4; a2[4] = 5; a2[5] = 6;
    x2[0] = 1; x2[1] = 1;
    e = '0; e[0] = 79; e[1] = 100;
    run(2, 0, 25, 2, e);
    e[0] = 3; e[1] = 7; e[2] = 11;
    run(2, 1, 14, 3, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
